// File: rtl/tick_sequencer.sv
// Per-tick unit scheduler: on each accepted tick, issues a start pulse to every
// enabled unit in index order and waits for its done (or a timeout) before moving on.
module tick_sequencer #(
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned TIMER_W   = 16,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 run,
   input  logic                 step,
   input  logic                 clear_flags,
   input  logic [NUM_UNITS-1:0] unit_en,
   input  logic [NUM_UNITS-1:0] done,
   output logic [NUM_UNITS-1:0] start,
   output logic                 busy,
   output logic                 seq_done,
   output logic [3:0]           cur_unit,
   output logic [15:0]          seq_count,
   output logic                 overrun,
   output logic                 timeout,
   output logic [3:0]           timeout_unit
);

   typedef enum logic [2:0] {StIdle, StSelect, StIssue, StWait, StFinish} state_e;

   localparam logic [3:0]         LastIdx   = 4'(NUM_UNITS);
   localparam logic [TIMER_W-1:0] TimeoutLd = TIMER_W'(TIMEOUT);
   localparam logic [TIMER_W-1:0] TimerOne  = TIMER_W'(1);

   state_e               state_q, state_d;
   logic [3:0]           idx_q, idx_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 step_armed_q, step_armed_d;
   logic [NUM_UNITS-1:0] start_q, start_d;
   logic                 busy_q, busy_d;
   logic                 seq_done_q, seq_done_d;
   logic [15:0]          seq_count_q, seq_count_d;
   logic                 overrun_q, overrun_d;
   logic                 timeout_q, timeout_d;
   logic [3:0]           timeout_unit_q, timeout_unit_d;
   logic                 trigger;
   logic [15:0]          sel_onehot;
   logic [15:0]          en_ext, done_ext;

   // Widened so a 4-bit index selects without range issues for any NUM_UNITS.
   assign en_ext   = 16'(unit_en);
   assign done_ext = 16'(done);

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      timer_d        = timer_q;
      seq_count_d    = seq_count_q;
      seq_done_d     = 1'b0;
      trigger        = 1'b0;
      sel_onehot     = '0;
      overrun_d      = (overrun_q & ~clear_flags) | (tick & busy_q);
      timeout_d      = timeout_q & ~clear_flags;
      timeout_unit_d = clear_flags ? 4'd0 : timeout_unit_q;

      unique case (state_q)
         StIdle: begin
            trigger = tick & (run | step_armed_q);
            if (trigger) begin
               idx_d   = 4'd0;
               state_d = StSelect;
            end
         end
         StSelect: begin
            if (idx_q == LastIdx) begin
               state_d = StFinish;
            end else if (en_ext[idx_q]) begin
               state_d = StIssue;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         StIssue: begin
            timer_d = TimeoutLd;
            state_d = StWait;
         end
         StWait: begin
            if (done_ext[idx_q]) begin
               idx_d   = idx_q + 4'd1;
               state_d = StSelect;
            end else if (timer_q == '0) begin
               timeout_d      = 1'b1;
               timeout_unit_d = idx_q;
               idx_d          = idx_q + 4'd1;
               state_d        = StSelect;
            end else begin
               timer_d = timer_q - TimerOne;
            end
         end
         StFinish: begin
            seq_count_d = seq_count_q + 16'd1;
            seq_done_d  = 1'b1;
            idx_d       = 4'd0;
            state_d     = StIdle;
         end
         default: begin
            idx_d   = 4'd0;
            state_d = StIdle;
         end
      endcase

      // A new step request wins over consumption in the same cycle.
      step_armed_d = (step & ~run) | (step_armed_q & ~trigger);
      busy_d       = (state_d != StIdle);
      sel_onehot   = 16'd1 << idx_d;
      start_d      = (state_d == StIssue) ? sel_onehot[NUM_UNITS-1:0] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         idx_q          <= 4'd0;
         timer_q        <= '0;
         step_armed_q   <= 1'b0;
         start_q        <= '0;
         busy_q         <= 1'b0;
         seq_done_q     <= 1'b0;
         seq_count_q    <= 16'd0;
         overrun_q      <= 1'b0;
         timeout_q      <= 1'b0;
         timeout_unit_q <= 4'd0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         timer_q        <= timer_d;
         step_armed_q   <= step_armed_d;
         start_q        <= start_d;
         busy_q         <= busy_d;
         seq_done_q     <= seq_done_d;
         seq_count_q    <= seq_count_d;
         overrun_q      <= overrun_d;
         timeout_q      <= timeout_d;
         timeout_unit_q <= timeout_unit_d;
      end
   end

   assign start        = start_q;
   assign busy         = busy_q;
   assign seq_done     = seq_done_q;
   assign cur_unit     = idx_q;
   assign seq_count    = seq_count_q;
   assign overrun      = overrun_q;
   assign timeout      = timeout_q;
   assign timeout_unit = timeout_unit_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: a procedural timeline model checks every output every cycle,
// alongside table-driven sequences and hand-written corner cases.
module tb_tick_sequencer;
   localparam int N     = 4;
   localparam int TO    = 5;
   localparam int BOUND = 400;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick = 1'b0, run = 1'b0, step = 1'b0, clear_flags = 1'b0;
   logic [N-1:0]  unit_en = '0;
   logic [N-1:0]  done;
   logic [N-1:0]  rsp_done = '0;
   logic [N-1:0]  rnd_done = '0;
   logic          rnd_mode = 1'b0;
   logic [N-1:0]  start;
   logic          busy, seq_done, overrun, timeout;
   logic [3:0]    cur_unit, timeout_unit;
   logic [15:0]   seq_count;

   assign done = rnd_mode ? rnd_done : rsp_done;

   tick_sequencer #(.NUM_UNITS(N), .TIMER_W(16), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .tick(tick), .run(run), .step(step), .clear_flags(clear_flags),
      .unit_en(unit_en), .done(done), .start(start), .busy(busy), .seq_done(seq_done),
      .cur_unit(cur_unit), .seq_count(seq_count), .overrun(overrun), .timeout(timeout),
      .timeout_unit(timeout_unit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Unit responder: rsp_dly[u]=d raises done[u] in the d-th WAIT cycle; 0 never answers.
   int rsp_dly [N];
   int rsp_cnt [N];
   always @(negedge clk) begin
      logic [N-1:0] d;
      d = '0;
      for (int u = 0; u < N; u++) begin
         if (rsp_cnt[u] > 0) begin
            rsp_cnt[u]--;
            if (rsp_cnt[u] == 0) d[u] = 1'b1;
         end
         if (start[u] && rsp_dly[u] > 0) rsp_cnt[u] = rsp_dly[u];
      end
      rsp_done = d;
   end

   // Reference model: one pass of the timeline per accepted tick.
   logic [N-1:0] m_start = '0;
   logic         m_busy = 0, m_sd = 0, m_over = 0, m_to = 0, m_armed = 0, m_trig = 0;
   logic [3:0]   m_cur = '0, m_to_unit = '0;
   logic [15:0]  m_count = '0;
   logic         s_tick, s_run, s_step, s_clr;
   logic [N-1:0] s_en, s_done;
   logic         model_on = 1'b0;

   task automatic step_edge();
      @(posedge clk);
      s_tick = tick; s_run = run; s_step = step; s_clr = clear_flags;
      s_en = unit_en; s_done = done;
      m_trig  = !m_busy && s_tick && (s_run || m_armed);
      m_armed = (s_step && !s_run) || (m_armed && !m_trig);
      if (s_clr) begin m_over = 0; m_to = 0; m_to_unit = '0; end
      if (s_tick && m_busy) m_over = 1;
      m_sd    = 1'b0;
      m_start = '0;
   endtask

   initial begin : model
      int w;
      @(negedge rst);
      forever begin
         do step_edge(); while (!m_trig);
         m_busy = 1; m_cur = '0;
         for (int u = 0; u < N; u++) begin
            step_edge();
            if (s_en[u]) begin
               m_start[u] = 1'b1;
               step_edge();
               w = 0;
               while (1) begin
                  step_edge();
                  if (s_done[u]) break;
                  if (w == TO) begin m_to = 1; m_to_unit = 4'(u); break; end
                  w++;
               end
            end
            m_cur = 4'(u + 1);
         end
         step_edge();
         step_edge();
         m_busy = 0; m_cur = '0; m_count++; m_sd = 1;
      end
   end

   // Monitor and per-cycle comparison, 1 time unit after the falling edge.
   logic         mon_clr = 1'b0;
   int           n_pulses, n_sd;
   logic [N-1:0] seen;
   int           cur_cyc [16];
   always begin
      @(negedge clk);
      #1;
      if (mon_clr) begin
         n_pulses = 0; n_sd = 0; seen = '0;
         for (int i = 0; i < 16; i++) cur_cyc[i] = 0;
      end else begin
         n_pulses += $countones(start);
         n_sd += int'(seq_done);
         seen |= start;
         cur_cyc[cur_unit]++;
      end
      if (model_on) begin
         check("start", start, m_start);
         check("busy", busy, m_busy);
         check("seq_done", seq_done, m_sd);
         check("cur_unit", cur_unit, m_cur);
         check("seq_count", seq_count, m_count);
         check("overrun", overrun, m_over);
         check("timeout", timeout, m_to);
         check("timeout_unit", timeout_unit, m_to_unit);
      end
   end

   task automatic pulse_tick();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear_flags = 1'b1; mon_clr = 1'b1;
      @(negedge clk); clear_flags = 1'b0; mon_clr = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < BOUND) begin @(negedge clk); n++; end
      check("idle_within_bound", busy, 1'b0);
      @(negedge clk);
   endtask

   task automatic set_rsp(input int d0, input int d1, input int d2, input int d3);
      rsp_dly[0] = d0; rsp_dly[1] = d1; rsp_dly[2] = d2; rsp_dly[3] = d3;
   endtask

   typedef struct {
      logic [N-1:0] en;
      int           d0, d1, d2, d3;
      logic [N-1:0] exp_seen;
      int           exp_pulses;
      logic         exp_to;
      logic [3:0]   exp_to_unit;
      int           exp_c1;    // cycles spent with cur_unit == 1
   } vec_t;

   vec_t tbl [5];
   int   exp_count = 0;
   int   acc, next_free, t, n;

   initial begin
      tbl[0] = '{4'b1111, 3, 3, 3, 3, 4'b1111, 4, 1'b0, 4'd0, 5};
      tbl[1] = '{4'b0101, 2, 2, 2, 2, 4'b0101, 2, 1'b0, 4'd0, 1};
      tbl[2] = '{4'b1111, 3, 0, 3, 3, 4'b1111, 4, 1'b1, 4'd1, 8};
      tbl[3] = '{4'b0000, 1, 1, 1, 1, 4'b0000, 0, 1'b0, 4'd0, 1};
      tbl[4] = '{4'b1010, 0, 4, 0, 0, 4'b1010, 2, 1'b1, 4'd3, 6};

      repeat (3) @(negedge clk);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_cur_unit", cur_unit, 0);
      check("rst_seq_count", seq_count, 0);
      check("rst_flags", {overrun, timeout, timeout_unit}, 0);
      rst = 1'b0;
      model_on = 1'b1;

      // Latency: tick latched at edge T, start[0] visible during cycle T+2.
      run = 1'b1; unit_en = 4'b1111; set_rsp(1, 1, 1, 1);
      pulse_tick();
      check("lat_select_busy", busy, 1'b1);
      check("lat_select_start", start, 4'b0000);
      @(negedge clk);
      check("lat_issue_start", start, 4'b0001);
      wait_idle();
      exp_count++;

      for (int i = 0; i < 5; i++) begin
         pulse_clear();
         check("clear_timeout", timeout, 1'b0);
         check("clear_timeout_unit", timeout_unit, 4'd0);
         unit_en = tbl[i].en;
         set_rsp(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
         pulse_tick();
         wait_idle();
         exp_count++;
         check($sformatf("v%0d_seen", i), seen, tbl[i].exp_seen);
         check($sformatf("v%0d_pulses", i), n_pulses, tbl[i].exp_pulses);
         check($sformatf("v%0d_seq_done", i), n_sd, 1);
         check($sformatf("v%0d_seq_count", i), seq_count, 16'(exp_count));
         check($sformatf("v%0d_timeout", i), timeout, tbl[i].exp_to);
         check($sformatf("v%0d_timeout_unit", i), timeout_unit, tbl[i].exp_to_unit);
         check($sformatf("v%0d_overrun", i), overrun, 1'b0);
         check($sformatf("v%0d_cur1_cycles", i), cur_cyc[1], tbl[i].exp_c1);
      end

      // Overrun: 4-cycle tick period against a 26-cycle busy sequence.
      pulse_clear();
      unit_en = 4'b1111; set_rsp(4, 4, 4, 4);
      acc = 0; next_free = 0;
      for (int k = 0; k < 12; k++) begin
         t = 4 * k;
         if (t >= next_free) begin acc++; next_free = t + N * (2 + 4) + 2 + 1; end
      end
      for (int k = 0; k < 12; k++) begin
         pulse_tick();
         repeat (2) @(negedge clk);
      end
      wait_idle();
      exp_count += acc;
      check("ovr_overrun", overrun, 1'b1);
      check("ovr_seq_count", seq_count, 16'(exp_count));
      check("ovr_pulses", n_pulses, 4 * acc);
      check("ovr_seq_done", n_sd, acc);

      // Pause, then one step consumed by the first of three ticks.
      pulse_clear();
      run = 1'b0; set_rsp(1, 1, 1, 1);
      for (int k = 0; k < 3; k++) begin pulse_tick(); repeat (20) @(negedge clk); end
      check("pause_pulses", n_pulses, 0);
      check("pause_seq_count", seq_count, 16'(exp_count));
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      for (int k = 0; k < 3; k++) begin pulse_tick(); repeat (20) @(negedge clk); end
      exp_count++;
      check("step_seq_done", n_sd, 1);
      check("step_pulses", n_pulses, 4);
      check("step_seq_count", seq_count, 16'(exp_count));
      // Step while running must not arm.
      @(negedge clk); run = 1'b1;
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      @(negedge clk); run = 1'b0;
      pulse_clear();
      for (int k = 0; k < 3; k++) begin pulse_tick(); repeat (20) @(negedge clk); end
      check("runstep_pulses", n_pulses, 0);
      check("runstep_seq_done", n_sd, 0);

      // Randomized traffic, every cycle checked against the model.
      run = 1'b1; rnd_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         tick = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) run = ~run;
         step = ($urandom_range(0, 15) == 0);
         clear_flags = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) unit_en = N'($urandom);
         for (int u = 0; u < N; u++) rnd_done[u] = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      tick = 1'b0; step = 1'b0; clear_flags = 1'b0; rnd_done = '1;
      wait_idle();
      rnd_done = '0; rnd_mode = 1'b0;

      // Reset mid-WAIT on unit 2, then a late done[2] arriving in IDLE.
      model_on = 1'b0;
      run = 1'b1; unit_en = 4'b1111; set_rsp(1, 1, 0, 1);
      pulse_tick();
      n = 0;
      while (!start[2] && n < 50) begin @(negedge clk); n++; end
      check("reach_issue2", start, 4'b0100);
      repeat (3) @(negedge clk);
      check("mid_wait_unit", cur_unit, 4'd2);
      #2 rst = 1'b1;
      #1;
      check("arst_start", start, 0);
      check("arst_busy", busy, 0);
      check("arst_seq_done", seq_done, 0);
      check("arst_cur_unit", cur_unit, 0);
      check("arst_seq_count", seq_count, 0);
      check("arst_flags", {overrun, timeout, timeout_unit}, 0);
      @(negedge clk); rst = 1'b0; rnd_mode = 1'b1; rnd_done = 4'b0100;
      @(negedge clk); rnd_done = '0; rnd_mode = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("late_done_busy", busy, 1'b0);
         check("late_done_start", start, 4'b0000);
      end

      // Wrap: preload 65535, one sequence brings it back to 0.
      force dut.seq_count_q = 16'hffff;
      @(negedge clk);
      release dut.seq_count_q;
      set_rsp(1, 1, 1, 1);
      pulse_clear();
      pulse_tick();
      wait_idle();
      check("wrap_seq_count", seq_count, 16'd0);
      check("wrap_seq_done", n_sd, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
